// File: rtl/hamming_secded_if.sv
// Valid/ready stream bundle for the SECDED decoder: codeword in, corrected word out.
// master is the environment side (producer + consumer), slave is the decoder.
interface hamming_secded_if #(
  parameter int DATA_W = 4,
  parameter int PAR_W  = 3
);
  localparam int N = DATA_W + PAR_W + 1;

  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      in_code;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err_single;
  logic              out_err_double;
  logic [PAR_W-1:0]  out_syndrome;

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_data, out_err_single, out_err_double, out_syndrome
  );

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_data, out_err_single, out_err_double, out_syndrome
  );
endinterface

// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined Hamming SECDED decoder with valid/ready streams and
// saturating counters of corrected and uncorrectable words.
module hamming_secded_decoder #(
  parameter int DATA_W = 4,
  parameter int PAR_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hamming_secded_if.slave      bus,
  input  logic                 clr_cnt,
  output logic [CNT_W-1:0]     corr_cnt,
  output logic [CNT_W-1:0]     uncorr_cnt
);
  localparam int          N        = DATA_W + PAR_W + 1;
  localparam int unsigned LAST_POS = N - 1;

  // Hamming position (1-based) of data bit j: the j-th non-power-of-two position.
  function automatic int data_pos(input int j);
    int res;
    int cnt;
    res = 0;
    cnt = 0;
    for (int pos = 1; pos < N; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (cnt == j) res = pos;
        cnt++;
      end
    end
    return res;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic adv;
  logic hs;

  assign adv         = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = adv & rst_n;
  assign hs          = bus.out_valid & bus.out_ready;

  // ---- stage 0: syndrome and overall parity of the incoming codeword ----
  logic [PAR_W-1:0] syn_p0;
  logic             par_p0;

  always_comb begin
    syn_p0 = '0;
    for (int k = 0; k < PAR_W; k++) begin
      for (int i = 0; i < N - 1; i++) begin
        if ((((i + 1) >> k) & 1) != 0) syn_p0[k] = syn_p0[k] ^ bus.in_code[i];
      end
    end
    par_p0 = ^bus.in_code;
  end

  // ---- stage 1 registers ----
  logic             vld_p1;
  logic [N-1:0]     code_p1;
  logic [PAR_W-1:0] syn_p1;
  logic             par_p1;

  always_ff @(posedge clk) begin
    if (!rst_n)   vld_p1 <= 1'b0;
    else if (adv) vld_p1 <= bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      code_p1 <= bus.in_code;
      syn_p1  <= syn_p0;
      par_p1  <= par_p0;
    end
  end

  // ---- stage 1 -> 2: classify, correct, extract data ----
  logic [N-1:0]      flip_mask_p1;
  logic [N-1:0]      fixed_p1;
  logic [DATA_W-1:0] data_p1;
  logic              single_p1;
  logic              double_p1;

  always_comb begin
    single_p1    = 1'b0;
    double_p1    = 1'b0;
    flip_mask_p1 = '0;
    if (syn_p1 == '0) begin
      single_p1 = par_p1;
    end else if (par_p1 && (32'(syn_p1) <= LAST_POS)) begin
      single_p1 = 1'b1;
      for (int i = 0; i < N - 1; i++) flip_mask_p1[i] = (syn_p1 == PAR_W'(i + 1));
    end else begin
      // Even parity with a nonzero syndrome, or a syndrome past the word end.
      double_p1 = 1'b1;
    end
    fixed_p1 = code_p1 ^ flip_mask_p1;
    data_p1  = '0;
    for (int j = 0; j < DATA_W; j++) data_p1[j] = fixed_p1[data_pos(j) - 1];
  end

  // ---- stage 2 registers: the out_* ports ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid      <= 1'b0;
      bus.out_data       <= '0;
      bus.out_err_single <= 1'b0;
      bus.out_err_double <= 1'b0;
      bus.out_syndrome   <= '0;
    end else if (adv) begin
      bus.out_valid      <= vld_p1;
      bus.out_data       <= data_p1;
      bus.out_err_single <= single_p1;
      bus.out_err_double <= double_p1;
      bus.out_syndrome   <= syn_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (clr_cnt) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (hs) begin
      if (bus.out_err_single) corr_cnt   <= sat_inc(corr_cnt);
      if (bus.out_err_double) uncorr_cnt <= sat_inc(uncorr_cnt);
    end
  end
endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Bench for hamming_secded_decoder: an 8-bit-codeword instance with 2-bit counters
// and a 13-bit-codeword instance, checked against a queue of expected words.
module tb_hamming_secded_decoder;
  typedef struct {
    logic [15:0] code;
    logic [7:0]  data;
    logic        single;
    logic        dbl;
    logic [3:0]  syn;
  } vec_t;

  logic clk;
  logic rst_n;
  logic clr_a, clr_b;
  logic [1:0]  corr_a, uncorr_a;
  logic [15:0] corr_b, uncorr_b;

  int n_tests = 0;
  int n_fail  = 0;

  vec_t tbl_a[10];
  vec_t tbl_b[5];
  vec_t q_a[$];
  vec_t q_b[$];
  vec_t cur_a, cur_b;

  hamming_secded_if #(.DATA_W(4), .PAR_W(3)) if_a ();
  hamming_secded_if #(.DATA_W(8), .PAR_W(4)) if_b ();

  hamming_secded_decoder #(.DATA_W(4), .PAR_W(3), .CNT_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a), .clr_cnt(clr_a),
    .corr_cnt(corr_a), .uncorr_cnt(uncorr_a)
  );

  hamming_secded_decoder #(.DATA_W(8), .PAR_W(4), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b), .clr_cnt(clr_b),
    .corr_cnt(corr_b), .uncorr_cnt(uncorr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t required earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboards: push on accepted input, pop on output handshake.
  always @(negedge clk) begin
    if (if_a.in_valid && if_a.in_ready) q_a.push_back(cur_a);
    if (if_a.out_valid && if_a.out_ready) begin
      if (q_a.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_unexpected: got word 0x%0h, expected no output", if_a.out_data);
      end else begin
        vec_t e;
        e = q_a.pop_front();
        check("a_data",   32'(if_a.out_data),       32'(e.data[3:0]));
        check("a_single", 32'(if_a.out_err_single), 32'(e.single));
        check("a_double", 32'(if_a.out_err_double), 32'(e.dbl));
        check("a_syn",    32'(if_a.out_syndrome),   32'(e.syn[2:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (if_b.in_valid && if_b.in_ready) q_b.push_back(cur_b);
    if (if_b.out_valid && if_b.out_ready) begin
      if (q_b.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_unexpected: got word 0x%0h, expected no output", if_b.out_data);
      end else begin
        vec_t e;
        e = q_b.pop_front();
        check("b_data",   32'(if_b.out_data),       32'(e.data));
        check("b_single", 32'(if_b.out_err_single), 32'(e.single));
        check("b_double", 32'(if_b.out_err_double), 32'(e.dbl));
        check("b_syn",    32'(if_b.out_syndrome),   32'(e.syn));
      end
    end
  end

  task automatic send_a(input vec_t v);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    cur_a = v;
    if_a.in_code = v.code[7:0];
    if_a.in_valid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (if_a.in_ready) ok = 1'b1;
      n++;
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL a_accept: in_ready stayed 0 for code 0x%0h, expected 1", v.code);
    end else begin
      @(posedge clk); #1;
    end
    if_a.in_valid = 1'b0;
  endtask

  task automatic send_b(input vec_t v);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    cur_b = v;
    if_b.in_code = v.code[12:0];
    if_b.in_valid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (if_b.in_ready) ok = 1'b1;
      n++;
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL b_accept: in_ready stayed 0 for code 0x%0h, expected 1", v.code);
    end else begin
      @(posedge clk); #1;
    end
    if_b.in_valid = 1'b0;
  endtask

  task automatic wait_out_valid_a();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if_a.out_valid && n < 50);
    if (!if_a.out_valid) begin
      n_tests++; n_fail++;
      $display("FAIL a_wait_valid: out_valid 0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic pulse_clr_a();
    clr_a = 1'b1;
    @(posedge clk); #1;
    clr_a = 1'b0;
  endtask

  initial begin
    // code, data, single, double, syndrome
    tbl_a[0] = '{16'h55, 8'hB, 1'b0, 1'b0, 4'd0};
    tbl_a[1] = '{16'h45, 8'hB, 1'b1, 1'b0, 4'd5};
    tbl_a[2] = '{16'hD5, 8'hB, 1'b1, 1'b0, 4'd0};
    tbl_a[3] = '{16'h56, 8'hB, 1'b0, 1'b1, 4'd3};
    tbl_a[4] = '{16'h54, 8'hB, 1'b1, 1'b0, 4'd1};
    tbl_a[5] = '{16'h51, 8'hB, 1'b1, 1'b0, 4'd3};
    tbl_a[6] = '{16'h15, 8'hB, 1'b1, 1'b0, 4'd7};
    tbl_a[7] = '{16'hFF, 8'hF, 1'b0, 1'b0, 4'd0};
    tbl_a[8] = '{16'hFC, 8'hF, 1'b0, 1'b1, 4'd3};
    tbl_a[9] = '{16'h00, 8'h0, 1'b0, 1'b0, 4'd0};

    tbl_b[0] = '{16'h0805, 8'h81, 1'b0, 1'b1, 4'd14};
    tbl_b[1] = '{16'h0004, 8'h00, 1'b1, 1'b0, 4'd3};
    tbl_b[2] = '{16'h0000, 8'h00, 1'b0, 1'b0, 4'd0};
    tbl_b[3] = '{16'h1004, 8'h01, 1'b0, 1'b1, 4'd3};
    tbl_b[4] = '{16'h0800, 8'h00, 1'b1, 1'b0, 4'd12};

    rst_n = 1'b0;
    clr_a = 1'b0;
    clr_b = 1'b0;
    if_a.in_valid = 1'b0; if_a.in_code = '0; if_a.out_ready = 1'b1;
    if_b.in_valid = 1'b0; if_b.in_code = '0; if_b.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",   32'(if_a.in_ready),       32'd0);
    check("rst_out_valid",  32'(if_a.out_valid),      32'd0);
    check("rst_out_data",   32'(if_a.out_data),       32'd0);
    check("rst_single",     32'(if_a.out_err_single), 32'd0);
    check("rst_double",     32'(if_a.out_err_double), 32'd0);
    check("rst_syn",        32'(if_a.out_syndrome),   32'd0);
    check("rst_corr",       32'(corr_a),              32'd0);
    check("rst_uncorr",     32'(uncorr_a),            32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Latency: two edges from capture to out_valid, counter one edge after handshake.
    send_a(tbl_a[1]);
    @(negedge clk);
    check("lat_edge1_valid", 32'(if_a.out_valid), 32'd0);
    @(negedge clk);
    check("lat_edge2_valid", 32'(if_a.out_valid), 32'd1);
    check("lat_corr_before", 32'(corr_a),         32'd0);
    @(negedge clk);
    check("lat_corr_after",  32'(corr_a),         32'd1);
    @(posedge clk); #1;
    pulse_clr_a();

    // Back-to-back table stream.
    for (int i = 0; i < 10; i++) send_a(tbl_a[i]);
    repeat (4) @(negedge clk);
    check("tbl_corr_sat", 32'(corr_a),   32'd3);
    check("tbl_uncorr",   32'(uncorr_a), 32'd2);

    // Reset with two words in flight.
    @(posedge clk); #1;
    if_a.out_ready = 1'b0;
    send_a(tbl_a[1]);
    send_a(tbl_a[3]);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(if_a.in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    q_a.delete();
    if_a.out_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_valid",  32'(if_a.out_valid), 32'd0);
    check("mid_rst_corr",   32'(corr_a),         32'd0);
    check("mid_rst_uncorr", 32'(uncorr_a),       32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_no_stale", 32'(if_a.out_valid), 32'd0);
    end

    // Back-pressure: three words, output stalled for three cycles.
    @(posedge clk); #1;
    pulse_clr_a();
    if_a.out_ready = 1'b0;
    fork
      begin
        send_a(tbl_a[0]);
        send_a(tbl_a[1]);
        send_a(tbl_a[3]);
      end
      begin
        wait_out_valid_a();
        for (int c = 0; c < 3; c++) begin
          if (c > 0) @(negedge clk);
          check("bp_valid",    32'(if_a.out_valid),      32'd1);
          check("bp_data",     32'(if_a.out_data),       32'hB);
          check("bp_single",   32'(if_a.out_err_single), 32'd0);
          check("bp_syn",      32'(if_a.out_syndrome),   32'd0);
          check("bp_in_ready", 32'(if_a.in_ready),       32'd0);
        end
        @(posedge clk); #1;
        if_a.out_ready = 1'b1;
      end
    join
    repeat (6) @(negedge clk);
    check("bp_corr",   32'(corr_a),   32'd1);
    check("bp_uncorr", 32'(uncorr_a), 32'd1);
    check("bp_queue",  32'(q_a.size()), 32'd0);

    // Saturation with 2-bit counters, then clear against a same-cycle increment.
    @(posedge clk); #1;
    pulse_clr_a();
    for (int i = 0; i < 3; i++) send_a(tbl_a[1]);
    repeat (4) @(negedge clk);
    check("cnt_three", 32'(corr_a), 32'd3);
    @(posedge clk); #1;
    send_a(tbl_a[1]);
    repeat (4) @(negedge clk);
    check("cnt_saturate", 32'(corr_a),   32'd3);
    check("cnt_uncorr0",  32'(uncorr_a), 32'd0);
    @(posedge clk); #1;
    if_a.out_ready = 1'b0;
    send_a(tbl_a[1]);
    wait_out_valid_a();
    @(posedge clk); #1;
    if_a.out_ready = 1'b1;
    clr_a = 1'b1;
    @(posedge clk); #1;
    clr_a = 1'b0;
    @(negedge clk);
    check("clr_wins_corr",  32'(corr_a),         32'd0);
    check("clr_consumed",   32'(if_a.out_valid), 32'd0);

    // Wider instance: out-of-range syndrome and edge positions.
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) send_b(tbl_b[i]);
    repeat (4) @(negedge clk);
    check("b_corr",   32'(corr_b),   32'd2);
    check("b_uncorr", 32'(uncorr_b), 32'd2);

    check("a_queue_empty", 32'(q_a.size()), 32'd0);
    check("b_queue_empty", 32'(q_b.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
